// File: rtl/regfile_debug_port.sv
// ---------------------------------------------------------------------------
// regfile_debug_port
//
// Debug access port into a 32 x 32-bit register file. It shares the
// register-file write port with the core writeback path, and the core always
// wins that port. Commands:
//   read  : return one register (x0 reads as 0, forwarded from a same-cycle
//           core write)
//   write : write one register once the core write port is free (x0 is not
//           written, and it acknowledges with data 0)
//   dump  : return x0..x31 in order, with o_RspLast set on x31
//   other : error response (o_RspErr=1, data 0)
//
// Ports
//   i_Clock, i_Reset_n                 clock, asynchronous active-low reset
//   i_CmdValid/o_CmdReady              command handshake (ready only in IDLE)
//   i_CmdOp/i_CmdReg/i_CmdData         command opcode, register, write data
//   i_CoreWriteEnable/RegDest/Data     core writeback request (priority)
//   o_RfWriteEnable/RegDest/DataIn     register file write port (combinational)
//   o_RfReadReg/i_RfReadData           register file read address / data
//   o_RspValid/i_RspReady              response handshake
//   o_RspData/o_RspReg/o_RspLast/o_RspErr  registered response payload
// ---------------------------------------------------------------------------
module regfile_debug_port (
    input  logic        i_Clock,
    input  logic        i_Reset_n,

    input  logic        i_CmdValid,
    output logic        o_CmdReady,
    input  logic [1:0]  i_CmdOp,
    input  logic [4:0]  i_CmdReg,
    input  logic [31:0] i_CmdData,

    input  logic        i_CoreWriteEnable,
    input  logic [4:0]  i_CoreRegDest,
    input  logic [31:0] i_CoreData,

    output logic        o_RfWriteEnable,
    output logic [4:0]  o_RfRegDest,
    output logic [31:0] o_RfDataIn,

    output logic [4:0]  o_RfReadReg,
    input  logic [31:0] i_RfReadData,

    output logic        o_RspValid,
    input  logic        i_RspReady,
    output logic [31:0] o_RspData,
    output logic [4:0]  o_RspReg,
    output logic        o_RspLast,
    output logic        o_RspErr
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0]  OP_READ  = OP_W'(0);
    localparam logic [OP_W-1:0]  OP_WRITE = OP_W'(1);
    localparam logic [OP_W-1:0]  OP_DUMP  = OP_W'(2);
    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);
    localparam logic [REG_W-1:0] REG_LAST = REG_W'(31);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } t_State;

    t_State             r_State;
    t_State             w_NextState;
    logic               r_Dump;
    logic [REG_W-1:0]   r_Addr;
    logic [DATA_W-1:0]  r_Data;

    logic               w_CmdFire;
    logic               w_RspFire;
    logic               w_DbgWrite;
    logic [DATA_W-1:0]  w_ReadValue;

    assign w_CmdFire = (r_State == IDLE) && i_CmdValid;
    assign w_RspFire = (r_State == RESP) && i_RspReady;

    // Read capture: x0 is hard zero; a same-cycle core write to the target wins
    always_comb begin
        w_ReadValue = i_RfReadData;
        if (r_Addr == REG_ZERO) begin
            w_ReadValue = '0;
        end else if (i_CoreWriteEnable && (i_CoreRegDest == r_Addr)) begin
            w_ReadValue = i_CoreData;
        end
    end

    // State register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_NextState = r_State;
        case (r_State)
            IDLE: begin
                if (w_CmdFire) begin
                    case (i_CmdOp)
                        OP_READ:  w_NextState = READ;
                        OP_WRITE: w_NextState = WRITE;
                        OP_DUMP:  w_NextState = READ;
                        default:  w_NextState = RESP;
                    endcase
                end
            end
            READ: begin
                w_NextState = RESP;
            end
            WRITE: begin
                // Core writeback owns the port; the debug write waits
                if (!i_CoreWriteEnable) begin
                    w_NextState = RESP;
                end
            end
            RESP: begin
                if (w_RspFire) begin
                    if (r_Dump && (r_Addr != REG_LAST)) begin
                        w_NextState = READ;
                    end else begin
                        w_NextState = IDLE;
                    end
                end
            end
            default: w_NextState = IDLE;
        endcase
    end

    // Combinational outputs: command ready, read address, write-port mux
    always_comb begin
        o_CmdReady      = 1'b0;
        o_RfReadReg     = REG_ZERO;
        w_DbgWrite      = 1'b0;
        o_RfWriteEnable = i_CoreWriteEnable;
        o_RfRegDest     = i_CoreRegDest;
        o_RfDataIn      = i_CoreData;

        case (r_State)
            IDLE:    o_CmdReady  = 1'b1;
            READ:    o_RfReadReg = r_Addr;
            WRITE:   w_DbgWrite  = !i_CoreWriteEnable;
            default: ;
        endcase

        // Debug drives the port only when the core is idle; x0 is never written
        if (w_DbgWrite) begin
            o_RfWriteEnable = (r_Addr != REG_ZERO);
            o_RfRegDest     = r_Addr;
            o_RfDataIn      = r_Data;
        end
    end

    // Command latches, dump walk and registered response payload
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Dump     <= 1'b0;
            r_Addr     <= REG_ZERO;
            r_Data     <= '0;
            o_RspValid <= 1'b0;
            o_RspData  <= '0;
            o_RspReg   <= REG_ZERO;
            o_RspLast  <= 1'b0;
            o_RspErr   <= 1'b0;
        end else begin
            case (r_State)
                IDLE: begin
                    if (w_CmdFire) begin
                        r_Data <= i_CmdData;
                        r_Dump <= (i_CmdOp == OP_DUMP);
                        r_Addr <= (i_CmdOp == OP_DUMP) ? REG_ZERO : i_CmdReg;
                        // Illegal op answers straight away with an error
                        if ((i_CmdOp != OP_READ) && (i_CmdOp != OP_WRITE) &&
                            (i_CmdOp != OP_DUMP)) begin
                            o_RspValid <= 1'b1;
                            o_RspData  <= '0;
                            o_RspReg   <= i_CmdReg;
                            o_RspLast  <= 1'b0;
                            o_RspErr   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    o_RspValid <= 1'b1;
                    o_RspData  <= w_ReadValue;
                    o_RspReg   <= r_Addr;
                    o_RspLast  <= r_Dump && (r_Addr == REG_LAST);
                    o_RspErr   <= 1'b0;
                end
                WRITE: begin
                    if (!i_CoreWriteEnable) begin
                        o_RspValid <= 1'b1;
                        o_RspData  <= (r_Addr == REG_ZERO) ? '0 : r_Data;
                        o_RspReg   <= r_Addr;
                        o_RspLast  <= 1'b0;
                        o_RspErr   <= 1'b0;
                    end
                end
                RESP: begin
                    // Payload holds until accepted
                    if (w_RspFire) begin
                        o_RspValid <= 1'b0;
                        if (r_Dump && (r_Addr != REG_LAST)) begin
                            r_Addr <= r_Addr + REG_W'(1);
                        end else begin
                            r_Dump <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
